// File: rtl/sr_cmd_gen_if.sv
// Request/command signal bundle between the raw request lines and sr_cmd_gen.
// The master drives the raw requests and observes the command pulses and status flags.
interface sr_cmd_gen_if;
    logic set_in;
    logic clr_in;
    logic S;
    logic R;
    logic conflict;
    logic dropped;

    modport master (
        output set_in,
        output clr_in,
        input  S,
        input  R,
        input  conflict,
        input  dropped
    );

    modport slave (
        input  set_in,
        input  clr_in,
        output S,
        output R,
        output conflict,
        output dropped
    );
endinterface

// File: rtl/sr_cmd_gen.sv
// Turns raw set/clear lines into debounced, mutually exclusive one-cycle S/R pulses
// for a downstream SR flip-flop, with a lockout gap after every command.
module sr_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int LOCKOUT   = 2,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    sr_cmd_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LOCKOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Channel index 0 is the set request, index 1 the clear request.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       level_r;
    logic [1:0]       prev_r;
    logic [1:0]       req_s;
    logic [CNT_W-1:0] db_cnt_r [2];

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W-1:0] gap_nxt_s;
    logic             s_r;
    logic             r_r;
    logic             conflict_r;
    logic             dropped_r;
    logic             s_nxt_s;
    logic             r_nxt_s;
    logic             conflict_nxt_s;
    logic             dropped_nxt_s;

    assign raw_s = {bus.clr_in, bus.set_in};
    assign req_s = level_r & ~prev_r;

    // Synchronizers, debounce counters and debounced-level edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r     <= 2'b00;
            sync2_r     <= 2'b00;
            level_r     <= 2'b00;
            prev_r      <= 2'b00;
            db_cnt_r[0] <= CNT_ZERO;
            db_cnt_r[1] <= CNT_ZERO;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            prev_r  <= level_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == level_r[i]) begin
                    db_cnt_r[i] <= CNT_ZERO;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    level_r[i]  <= sync2_r[i];
                    db_cnt_r[i] <= CNT_ZERO;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Command FSM: next state, gap counter and next output values.
    always_comb begin
        state_nxt_s    = state_r;
        gap_nxt_s      = gap_r;
        s_nxt_s        = 1'b0;
        r_nxt_s        = 1'b0;
        conflict_nxt_s = 1'b0;
        dropped_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s == 2'b11) begin
                    conflict_nxt_s = 1'b1;
                end else if (req_s[0]) begin
                    s_nxt_s     = 1'b1;
                    state_nxt_s = ISSUE;
                end else if (req_s[1]) begin
                    r_nxt_s     = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                dropped_nxt_s = |req_s;
                gap_nxt_s     = GAP_LAST;
                state_nxt_s   = GAP;
            end
            GAP: begin
                dropped_nxt_s = |req_s;
                if (gap_r == CNT_ZERO) begin
                    state_nxt_s = IDLE;
                end else begin
                    gap_nxt_s = gap_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gap_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            gap_r      <= CNT_ZERO;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            conflict_r <= 1'b0;
            dropped_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            gap_r      <= gap_nxt_s;
            s_r        <= s_nxt_s;
            r_r        <= r_nxt_s;
            conflict_r <= conflict_nxt_s;
            dropped_r  <= dropped_nxt_s;
        end
    end

    assign bus.S        = s_r;
    assign bus.R        = r_r;
    assign bus.conflict = conflict_r;
    assign bus.dropped  = dropped_r;
endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, meaning consecutive stable synchronized samples (>=1) required to accept a level change.
REQ-002 Parameter LOCKOUT, default 2, meaning idle gap cycles (>=1) after each issued command.
REQ-003 Parameter CNT_W, default 8, meaning debounce/lockout counter width; DB_CYCLES and LOCKOUT SHALL be < 2**CNT_W.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 set_in  input  1  raw asynchronous set request (button/line).
REQ-007 clr_in  input  1  raw asynchronous clear request.
REQ-008 S  output  1  registered one-cycle set pulse, feeds the downstream SR flip-flop S input.
REQ-009 R  output  1  registered one-cycle reset pulse, feeds the downstream SR flip-flop R input.
REQ-010 conflict  output  1  registered one-cycle flag: simultaneous set and clear requests rejected.
REQ-011 dropped  output  1  registered one-cycle flag: request discarded during ISSUE/GAP.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-013 Per channel debounce: s2 == debounced level -> counter cleared; s2 != level -> counter increments; on an edge where counter == DB_CYCLES-1 and s2 still differs -> level <= s2, counter <= 0.
REQ-014 Request SHALL be the rising edge of the debounced level only (level high, previous level low); falling edges SHALL generate nothing.
REQ-015 Raw input first sampled high at edge k and held -> debounced level high after edge k+1+DB_CYCLES, S (or R) high for exactly the cycle following edge k+2+DB_CYCLES.
REQ-016 FSM states IDLE, ISSUE, GAP; IDLE is the reset state.
REQ-017 IDLE, set request only -> S<=1, go ISSUE; clear request only -> R<=1, go ISSUE.
REQ-018 IDLE, set and clear requests in same cycle -> S, R stay 0, conflict<=1 for one cycle, remain IDLE.
REQ-019 ISSUE -> GAP after one cycle; S and R SHALL return to 0; gap counter loaded.
REQ-020 GAP lasts exactly LOCKOUT cycles, then IDLE.
REQ-021 Any request arriving in ISSUE or GAP SHALL be discarded, not queued; dropped<=1 for one cycle per discarding cycle.
REQ-022 S and R SHALL never be high in the same cycle; each pulse SHALL be exactly one cycle wide.
REQ-023 A held input SHALL yield exactly one command; a new command requires release (debounced low) and re-press.
REQ-024 All counters SHALL saturate/clear as specified, never wrap.

Reset
REQ-025 rst high SHALL immediately (asynchronously) force S=0, R=0, conflict=0, dropped=0, FSM=IDLE, all synchronizer flops, debounced levels, and counters to 0.
REQ-026 Reset asserted mid-ISSUE or mid-GAP SHALL abort the pulse/gap with no residual command after release.
REQ-027 An input already high when rst deasserts SHALL be treated as a fresh rising edge (one command, REQ-015 latency from first post-reset sample).

Verification (DB_CYCLES=4, LOCKOUT=2)
REQ-028 set_in 0->1 sampled at edge 10, held -> S=1 only in cycle after edge 16; R, conflict, dropped stay 0; no further S while held.
REQ-029 set_in high for 3 cycles then low -> S never asserted, debounced level stays 0.
REQ-030 set_in and clr_in rise on same edge 10 -> conflict=1 in cycle after edge 16; S=R=0 throughout.
REQ-031 set_in rises edge 10, clr_in rises edge 11 -> S pulse after edge 16; clr request lands in ISSUE -> dropped=1 after edge 17, R never asserted.
REQ-032 set_in rises edge 10, released edge 20, clr_in rises edge 30 -> S after edge 16, R after edge 36, each one cycle.
REQ-033 rst asserted asynchronously while S=1 -> S falls without clock edge; after rst release with set_in held high from edge 50 sampled -> single S after edge 56.
